// File: rtl/relu_pkg.sv
// relu_pkg: shared defaults, mode constants, lane word type and popcount for the ReLU stream
package relu_pkg;
  localparam int RELU_MSB_W = 6;
  localparam int RELU_LSB_W = 12;
  localparam int RELU_DATA_W = RELU_MSB_W + RELU_LSB_W;
  localparam int RELU_LANES = 4;
  localparam int RELU_LEAK_SHIFT = 3;
  localparam int RELU_CNT_W = 16;
  localparam logic RELU_MODE_PLAIN = 1'b0;
  localparam logic RELU_MODE_LEAKY = 1'b1;
  typedef logic signed [RELU_DATA_W-1:0] lane_t;
  function automatic logic [5:0] popcount(input logic [31:0] m);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount += 6'(m[i]);
  endfunction
endpackage

// File: rtl/relu_stream_if.sv
// relu_stream_if: input/output valid-ready beat bundle of the ReLU stream
interface relu_stream_if #(
  parameter int MSB_W = 6,
  parameter int LSB_W = 12,
  parameter int LANES = 4,
  parameter int DATA_W = MSB_W + LSB_W
);
  logic in_valid;
  logic in_ready;
  logic [LANES*MSB_W-1:0] in_msb;
  logic [LANES*LSB_W-1:0] in_lsb;
  logic in_mode;
  logic out_valid;
  logic out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0] out_neg_mask;
  modport master (
    output in_valid, in_msb, in_lsb, in_mode, out_ready,
    input in_ready, out_valid, out_data, out_neg_mask
  );
  modport slave (
    input in_valid, in_msb, in_lsb, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg_mask
  );
endinterface

// File: rtl/relu_lane.sv
// relu_lane: joins one split signed word and applies ReLU/leaky ReLU (ReLU-N clamp with RELU_CLAMP_EN)
module relu_lane
  import relu_pkg::*;
#(
  parameter int MSB_W = RELU_MSB_W,
  parameter int LSB_W = RELU_LSB_W,
  parameter int LEAK_SHIFT = RELU_LEAK_SHIFT
) (
  input logic [MSB_W-1:0] msb,
  input logic [LSB_W-1:0] lsb,
  input logic mode,
`ifdef RELU_CLAMP_EN
  input logic [MSB_W+LSB_W-1:0] clamp,
`endif
  output logic [MSB_W+LSB_W-1:0] y,
  output logic neg
);
  localparam int DATA_W = MSB_W + LSB_W;
  logic signed [DATA_W-1:0] x;
  logic [DATA_W-1:0] pos;
  assign x = {msb, lsb};
  assign neg = x[DATA_W-1];
`ifdef RELU_CLAMP_EN
  assign pos = (DATA_W'(x) > clamp) ? clamp : DATA_W'(x);
`else
  assign pos = DATA_W'(x);
`endif
  always_comb begin
    y = neg ? ((mode == RELU_MODE_LEAKY) ? DATA_W'(x >>> LEAK_SHIFT) : '0) : pos;
  end
endmodule

// File: rtl/relu_stream.sv
// relu_stream: multi-lane ReLU with 2-stage elastic pipeline and negative counter (cfg_clamp with RELU_CLAMP_EN)
module relu_stream
  import relu_pkg::*;
#(
  parameter int MSB_W = RELU_MSB_W,
  parameter int LSB_W = RELU_LSB_W,
  parameter int LANES = RELU_LANES,
  parameter int LEAK_SHIFT = RELU_LEAK_SHIFT,
  parameter int CNT_W = RELU_CNT_W
) (
  input logic clk,
  input logic rst,
  relu_stream_if.slave s,
  input logic cnt_clr,
`ifdef RELU_CLAMP_EN
  input logic [MSB_W+LSB_W-1:0] cfg_clamp,
`endif
  output logic [CNT_W-1:0] neg_cnt
);
  localparam int DATA_W = MSB_W + LSB_W;
  logic [LANES*DATA_W-1:0] lane_y, s1_data, s2_data;
  logic [LANES-1:0] lane_neg, s1_mask, s2_mask;
  logic s1_valid, s2_valid, s1_load, s2_load, accept;
  logic [5:0] pop;
  logic [CNT_W+6:0] sum;
  logic [CNT_W-1:0] cnt_next;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    relu_lane #(.MSB_W(MSB_W), .LSB_W(LSB_W), .LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .msb(s.in_msb[i*MSB_W +: MSB_W]),
      .lsb(s.in_lsb[i*LSB_W +: LSB_W]),
      .mode(s.in_mode),
`ifdef RELU_CLAMP_EN
      .clamp(cfg_clamp),
`endif
      .y(lane_y[i*DATA_W +: DATA_W]),
      .neg(lane_neg[i])
    );
  end
  assign s2_load = !s2_valid || s.out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign accept = s.in_valid && s1_load;
  assign s.in_ready = s1_load;
  assign s.out_valid = s2_valid;
  assign s.out_data = s2_data;
  assign s.out_neg_mask = s2_mask;
  assign pop = popcount(32'(lane_neg));
  assign sum = {7'b0, neg_cnt} + (CNT_W+7)'(pop);
  // clear wins over a simultaneous accept; overflow sticks at all-ones
  always_comb begin
    cnt_next = cnt_clr ? '0 : !accept ? neg_cnt : |sum[CNT_W+6:CNT_W] ? '1 : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data <= '0;
      s1_mask <= '0;
      s2_data <= '0;
      s2_mask <= '0;
      neg_cnt <= '0;
    end else begin
      if (s1_load) s1_valid <= s.in_valid;
      if (accept) begin
        s1_data <= lane_y;
        s1_mask <= lane_neg;
      end
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        s2_data <= s1_data;
        s2_mask <= s1_mask;
      end
      neg_cnt <= cnt_next;
    end
  end
endmodule

// File: tb/tb_relu_stream.sv
// tb_relu_stream: randomized scoreboard bench for relu_stream (clamp cases with RELU_CLAMP_EN)
module tb_relu_stream;
  localparam int MW = 6, LW = 12, DW = 18, NL = 4;
  typedef struct packed {logic [NL*DW-1:0] d; logic [NL-1:0] m;} beat_t;
  logic clk = 0, rst = 1, cnt_clr = 0, cnt_clr2 = 0, done = 0;
  logic [15:0] neg_cnt, exp_cnt = 0;
  logic [3:0] neg_cnt2;
  int errors = 0, checks = 0, rx_count = 0;
  beat_t q[$];
  beat_t e;
  logic [NL*DW-1:0] prev_data, w_in;
  logic [NL-1:0] prev_mask, m_in;
  logic prev_stall = 0;
  int tmp_cnt;
  always #5 clk = ~clk;
  relu_stream_if #(.MSB_W(MW), .LSB_W(LW), .LANES(NL)) a ();
  relu_stream_if #(.MSB_W(MW), .LSB_W(LW), .LANES(NL)) b ();
`ifdef RELU_CLAMP_EN
  logic [DW-1:0] cfg_clamp = '1;
`endif
  relu_stream dut (
    .clk(clk), .rst(rst), .s(a.slave), .cnt_clr(cnt_clr),
`ifdef RELU_CLAMP_EN
    .cfg_clamp(cfg_clamp),
`endif
    .neg_cnt(neg_cnt)
  );
  relu_stream #(.CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .s(b.slave), .cnt_clr(cnt_clr2),
`ifdef RELU_CLAMP_EN
    .cfg_clamp(cfg_clamp),
`endif
    .neg_cnt(neg_cnt2)
  );

  function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] w, input logic mode);
    logic signed [DW-1:0] sw;
    int x, y;
    logic [31:0] yy;
    sw = w;
    x = sw;
    if (x < 0) y = mode ? -((-x + 7) / 8) : 0;
    else begin
      y = x;
`ifdef RELU_CLAMP_EN
      if (x > int'(cfg_clamp)) y = int'(cfg_clamp);
`endif
    end
    yy = y;
    return yy[DW-1:0];
  endfunction

  function automatic logic [NL*DW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[NL*DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt = 0;
      prev_stall = 0;
    end else begin
      checks++;
      if (neg_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL neg_cnt got=%0d want=%0d", neg_cnt, exp_cnt);
      end
      if (prev_stall) begin
        checks++;
        if (a.out_valid !== 1'b1 || a.out_data !== prev_data || a.out_neg_mask !== prev_mask) begin
          errors++;
          $display("FAIL stall_hold got v=%b d=%h m=%b want v=1 d=%h m=%b", a.out_valid, a.out_data, a.out_neg_mask, prev_data, prev_mask);
        end
      end
      if (a.out_valid && a.out_ready) begin
        checks++;
        rx_count++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got d=%h want none", a.out_data);
        end else begin
          e = q.pop_front();
          if (a.out_data !== e.d || a.out_neg_mask !== e.m) begin
            errors++;
            $display("FAIL beat got d=%h m=%b want d=%h m=%b", a.out_data, a.out_neg_mask, e.d, e.m);
          end
        end
      end
      if (a.in_valid && a.in_ready) begin
        for (int i = 0; i < NL; i++) begin
          w_in[i*DW +: DW] = {a.in_msb[i*MW +: MW], a.in_lsb[i*LW +: LW]};
          m_in[i] = w_in[i*DW + DW - 1];
          e.d[i*DW +: DW] = ref_lane(w_in[i*DW +: DW], a.in_mode);
        end
        e.m = m_in;
        q.push_back(e);
      end
      tmp_cnt = exp_cnt + ((a.in_valid && a.in_ready) ? $countones(m_in) : 0);
      exp_cnt = cnt_clr ? 16'd0 : (tmp_cnt > 65535) ? 16'hFFFF : 16'(tmp_cnt);
      prev_stall = a.out_valid && !a.out_ready;
      prev_data = a.out_data;
      prev_mask = a.out_neg_mask;
    end
  end

  task automatic send(input logic [NL*DW-1:0] w, input logic mode);
    bit ok = 0;
    for (int i = 0; i < NL; i++) begin
      a.in_msb[i*MW +: MW] = w[i*DW + LW +: MW];
      a.in_lsb[i*LW +: LW] = w[i*DW +: LW];
    end
    a.in_mode = mode;
    a.in_valid = 1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = a.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 want 1 within 50 cycles");
    end
  endtask

  task automatic wait_drain(input int target);
    for (int t = 0; t < 200 && rx_count < target; t++) @(negedge clk);
    checks++;
    if (rx_count !== target) begin
      errors++;
      $display("FAIL drain got=%0d want=%0d", rx_count, target);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b0 || neg_cnt !== 16'd0 || a.out_data !== '0 || a.out_neg_mask !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b cnt=%0d d=%h m=%b want 0", a.out_valid, neg_cnt, a.out_data, a.out_neg_mask);
    end
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", a.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send({54'd0, 18'h01001}, 0);
    a.in_valid = 0;
    @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got out_valid=%b want=0", a.out_valid);
    end
    @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data[DW-1:0] !== 18'h01001 || a.out_neg_mask[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_pos got v=%b d=%h m=%b want v=1 d=01001 m0=0", a.out_valid, a.out_data[DW-1:0], a.out_neg_mask[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_neg();
    send({54'd0, 6'b100001, 12'h001}, 0);
    a.in_valid = 0;
    @(negedge clk);
    checks++;
    if (neg_cnt !== 16'd1) begin
      errors++;
      $display("FAIL neg_cnt_inc got=%0d want=1", neg_cnt);
    end
    @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data[DW-1:0] !== 18'h0 || a.out_neg_mask[0] !== 1'b1) begin
      errors++;
      $display("FAIL plain_neg got v=%b d=%h m0=%b want v=1 d=0 m0=1", a.out_valid, a.out_data[DW-1:0], a.out_neg_mask[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_leaky();
    send({18'h20000, 18'h0F000, 18'h3FFFF, 18'h3FFC0}, 1);
    a.in_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (a.out_data !== {18'h3C000, 18'h0F000, 18'h3FFFF, 18'h3FFF8} || a.out_neg_mask !== 4'b1011) begin
      errors++;
      $display("FAIL leaky got d=%h m=%b want d=%h m=1011", a.out_data, a.out_neg_mask, {18'h3C000, 18'h0F000, 18'h3FFFF, 18'h3FFF8});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int start = rx_count;
    bit saw_low = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_word(), 1'($urandom_range(0, 1)));
        a.in_valid = 0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 a.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 a.out_ready = 1;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (a.in_valid && !a.in_ready) saw_low = 1;
        end
      end
    join
    checks++;
    if (!saw_low) begin
      errors++;
      $display("FAIL backpressure got in_ready never low want low while stalled");
    end
    wait_drain(start + 6);
  endtask

  task automatic test_random();
    int start = rx_count;
    done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) send(rand_word(), 1'($urandom_range(0, 1)));
        a.in_valid = 0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          a.out_ready = ($urandom_range(0, 3) != 0);
          cnt_clr = ($urandom_range(0, 31) == 0);
        end
      end
    join
    a.out_ready = 1;
    cnt_clr = 0;
    wait_drain(start + 150);
  endtask

`ifdef RELU_CLAMP_EN
  task automatic test_clamp();
    int start = rx_count;
    cfg_clamp = 18'd100;
    send({18'd50, 18'h3FFC0, 18'd100, 18'd200}, 1);
    a.in_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (a.out_data !== {18'd50, 18'h3FFF8, 18'd100, 18'd100}) begin
      errors++;
      $display("FAIL clamp got d=%h want d=%h", a.out_data, {18'd50, 18'h3FFF8, 18'd100, 18'd100});
    end
    wait_drain(start + 1);
    cfg_clamp = '1;
  endtask
`endif

  task automatic test_saturation();
    logic [31:0] r;
    r = $urandom();
    for (int i = 0; i < NL; i++) b.in_msb[i*MW +: MW] = r[i*MW +: MW] | 6'b100000;
    b.in_lsb = 48'($urandom());
    b.in_valid = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (neg_cnt2 !== 4'((4 * k > 15) ? 15 : 4 * k)) begin
        errors++;
        $display("FAIL saturate_%0d got=%0d want=%0d", k, neg_cnt2, (4 * k > 15) ? 15 : 4 * k);
      end
    end
    cnt_clr2 = 1;
    @(negedge clk);
    checks++;
    if (neg_cnt2 !== 4'd0) begin
      errors++;
      $display("FAIL clear_priority got=%0d want=0", neg_cnt2);
    end
    cnt_clr2 = 0;
    b.in_valid = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_flush();
    a.out_ready = 0;
    send({4{18'h3FF00}}, 0);
    send(rand_word(), 1);
    a.in_valid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b0 || neg_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_flush got v=%b cnt=%0d want v=0 cnt=0", a.out_valid, neg_cnt);
    end
    @(posedge clk);
    #1 rst = 0;
    a.out_ready = 1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (a.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_beat got out_valid=%b want=0", a.out_valid);
      end
    end
  endtask

  initial begin
    a.in_valid = 0;
    a.in_msb = '0;
    a.in_lsb = '0;
    a.in_mode = 0;
    a.out_ready = 1;
    b.in_valid = 0;
    b.in_msb = '0;
    b.in_lsb = '0;
    b.in_mode = 0;
    b.out_ready = 1;
    test_reset();
    test_basic();
    test_neg();
    test_leaky();
    test_back_to_back();
    test_random();
`ifdef RELU_CLAMP_EN
    test_clamp();
`endif
    test_saturation();
    test_rst_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
